// File: rtl/palette_pkg.sv
// Shared types and helpers for the sprite palette bank: colour packing,
// fade states, the power-on palette contents and the per-channel fade.
package palette_pkg;

    localparam int COLOR_W = 4;
    localparam logic [COLOR_W-1:0] MAX = '1;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        FULL,
        FADING_OUT,
        BLACK,
        FADING_IN
    } fade_state_t;

    // The key index powers up as magenta so unhandled transparency is obvious on screen.
    function automatic rgb_t default_entry(input int idx, input int key);
        rgb_t e;
        if (idx == key) begin
            e.r = MAX;
            e.g = '0;
            e.b = MAX;
        end else begin
            e.r = COLOR_W'(idx);
            e.g = COLOR_W'(idx);
            e.b = COLOR_W'(idx);
        end
        return e;
    endfunction

    function automatic logic [COLOR_W-1:0] fade_channel(input logic [COLOR_W-1:0] ch,
                                                        input logic [COLOR_W-1:0] level);
        logic [COLOR_W-1:0] dim;
        dim = MAX - level;
        return (ch > dim) ? (ch - dim) : '0;
    endfunction

endpackage

// File: rtl/palette_fade_ctrl.sv
// Frame-stepped brightness controller: walks fade_level between black and
// full brightness, one step every FADE_FRAMES frame ticks.
module palette_fade_ctrl
    import palette_pkg::*;
#(
    parameter int FADE_FRAMES = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_frame_tick,
    input  logic               i_fade_out_req,
    input  logic               i_fade_in_req,
    output logic [COLOR_W-1:0] o_fade_level,
    output logic               o_fade_done
);

    localparam int CNT_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_FRAMES - 1);

    fade_state_t        r_state, w_state_next;
    logic [CNT_W-1:0]   r_tick_cnt, w_tick_cnt_next;
    logic [COLOR_W-1:0] r_level, w_level_next;
    logic               r_done, w_done_next;
    logic               w_go_out, w_go_in, w_step;

    // Fade-out has priority when both requests land together.
    assign w_go_out = i_fade_out_req;
    assign w_go_in  = i_fade_in_req && !i_fade_out_req;
    assign w_step   = i_frame_tick && (r_tick_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= FULL;
            r_tick_cnt <= '0;
            r_level    <= MAX;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tick_cnt <= w_tick_cnt_next;
            r_level    <= w_level_next;
            r_done     <= w_done_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_tick_cnt_next = r_tick_cnt;
        w_level_next    = r_level;
        w_done_next     = 1'b0;
        case (r_state)
            FULL: begin
                if (w_go_out) begin
                    w_state_next    = FADING_OUT;
                    w_tick_cnt_next = '0;
                end
            end
            BLACK: begin
                if (w_go_in) begin
                    w_state_next    = FADING_IN;
                    w_tick_cnt_next = '0;
                end
            end
            FADING_OUT: begin
                if (w_go_in) begin
                    w_state_next    = FADING_IN;
                    w_tick_cnt_next = '0;
                end else if (w_step) begin
                    w_tick_cnt_next = '0;
                    // A reversal can leave us at the endpoint already, so saturate here.
                    if (r_level <= 1'b1) begin
                        w_level_next = '0;
                        w_state_next = BLACK;
                        w_done_next  = 1'b1;
                    end else begin
                        w_level_next = r_level - 1'b1;
                    end
                end else if (i_frame_tick) begin
                    w_tick_cnt_next = r_tick_cnt + 1'b1;
                end
            end
            FADING_IN: begin
                if (w_go_out) begin
                    w_state_next    = FADING_OUT;
                    w_tick_cnt_next = '0;
                end else if (w_step) begin
                    w_tick_cnt_next = '0;
                    if (r_level >= MAX - 1'b1) begin
                        w_level_next = MAX;
                        w_state_next = FULL;
                        w_done_next  = 1'b1;
                    end else begin
                        w_level_next = r_level + 1'b1;
                    end
                end else if (i_frame_tick) begin
                    w_tick_cnt_next = r_tick_cnt + 1'b1;
                end
            end
            default: w_state_next = FULL;
        endcase
    end

    assign o_fade_level = r_level;
    assign o_fade_done  = r_done;

endmodule

// File: rtl/sprite_palette_bank.sv
// Runtime-writable multi-bank sprite palette with transparency key and
// fade engine; self-loads a default palette after every reset.
module sprite_palette_bank
    import palette_pkg::*;
#(
    parameter int INDEX_W     = 4,
    parameter int NUM_BANKS   = 4,
    parameter int KEY_INDEX   = 0,
    parameter int FADE_FRAMES = 2,
    localparam int BANK_W     = $clog2(NUM_BANKS)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_frame_tick,
    input  logic                 i_wr_en,
    input  logic [BANK_W-1:0]    i_wr_bank,
    input  logic [INDEX_W-1:0]   i_wr_index,
    input  logic [3*COLOR_W-1:0] i_wr_rgb,
    output logic                 o_wr_ready,
    input  logic                 i_pix_valid,
    input  logic [BANK_W-1:0]    i_pix_bank,
    input  logic [INDEX_W-1:0]   i_pix_index,
    output logic                 o_out_valid,
    output logic [COLOR_W-1:0]   o_red,
    output logic [COLOR_W-1:0]   o_green,
    output logic [COLOR_W-1:0]   o_blue,
    output logic                 o_transparent,
    input  logic                 i_fade_out_req,
    input  logic                 i_fade_in_req,
    output logic [COLOR_W-1:0]   o_fade_level,
    output logic                 o_fade_done
);

    localparam int ADDR_W = BANK_W + INDEX_W;
    localparam int DEPTH  = NUM_BANKS * (2 ** INDEX_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {INIT, RUN} init_state_t;

    init_state_t        r_init_state, w_init_state_next;
    logic [ADDR_W-1:0]  r_init_addr;
    rgb_t               r_mem [DEPTH];
    logic               w_mem_we;
    logic [ADDR_W-1:0]  w_mem_waddr;
    rgb_t               w_mem_wdata;
    rgb_t               r_s1_rgb;
    logic               r_s1_valid, r_s1_trans;
    logic               r_out_valid, r_transparent;
    logic [COLOR_W-1:0] r_red, r_green, r_blue;
    logic [COLOR_W-1:0] w_fade_level;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_init_state <= INIT;
            r_init_addr  <= '0;
        end else begin
            r_init_state <= w_init_state_next;
            if (r_init_state == INIT) r_init_addr <= r_init_addr + 1'b1;
        end
    end

    always_comb begin
        w_init_state_next = r_init_state;
        if (r_init_state == INIT && r_init_addr == LAST_ADDR) w_init_state_next = RUN;
    end

    // The init walk owns the write port; user writes only get through in RUN.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = {i_wr_bank, i_wr_index};
        w_mem_wdata = i_wr_rgb;
        if (!i_reset) begin
            if (r_init_state == INIT) begin
                w_mem_we    = 1'b1;
                w_mem_waddr = r_init_addr;
                w_mem_wdata = default_entry(int'(r_init_addr[INDEX_W-1:0]), KEY_INDEX);
            end else if (i_wr_en) begin
                w_mem_we = 1'b1;
            end
        end
    end

    // Read and write share one clocked block so a same-address collision returns old data.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
        r_s1_rgb <= r_mem[{i_pix_bank, i_pix_index}];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_valid    <= 1'b0;
            r_s1_trans    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_transparent <= 1'b0;
        end else begin
            r_s1_valid  <= i_pix_valid && (r_init_state == RUN);
            r_s1_trans  <= (i_pix_index == INDEX_W'(KEY_INDEX));
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_red         <= fade_channel(r_s1_rgb.r, w_fade_level);
                r_green       <= fade_channel(r_s1_rgb.g, w_fade_level);
                r_blue        <= fade_channel(r_s1_rgb.b, w_fade_level);
                r_transparent <= r_s1_trans;
            end
        end
    end

    palette_fade_ctrl #(
        .FADE_FRAMES(FADE_FRAMES)
    ) u_fade (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_frame_tick  (i_frame_tick),
        .i_fade_out_req(i_fade_out_req),
        .i_fade_in_req (i_fade_in_req),
        .o_fade_level  (w_fade_level),
        .o_fade_done   (o_fade_done)
    );

    assign o_wr_ready    = (r_init_state == RUN);
    assign o_out_valid   = r_out_valid;
    assign o_red         = r_red;
    assign o_green       = r_green;
    assign o_blue        = r_blue;
    assign o_transparent = r_transparent;
    assign o_fade_level  = w_fade_level;

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Scoreboard bench for sprite_palette_bank: a behavioural palette model feeds an
// expected-output queue that a free-running monitor drains on out_valid.
`timescale 1ns/1ps
module tb_sprite_palette_bank;

    localparam int INDEX_W     = 4;
    localparam int NUM_BANKS   = 4;
    localparam int KEY_INDEX   = 0;
    localparam int FADE_FRAMES = 2;
    localparam int ENTRIES     = 16;
    localparam int DEPTH       = NUM_BANKS * ENTRIES;

    typedef struct {
        logic [11:0] rgb;
        logic        trans;
        int          issueCycle;
    } expItem_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frameTick = 1'b0;
    logic        wrEn = 1'b0;
    logic [1:0]  wrBank = '0;
    logic [3:0]  wrIndex = '0;
    logic [11:0] wrRgb = '0;
    logic        wrReady;
    logic        pixValid = 1'b0;
    logic [1:0]  pixBank = '0;
    logic [3:0]  pixIndex = '0;
    logic        outValid;
    logic [3:0]  red, green, blue;
    logic        transparent;
    logic        fadeOutReq = 1'b0;
    logic        fadeInReq = 1'b0;
    logic [3:0]  fadeLevel;
    logic        fadeDone;

    logic [11:0] modelMem [DEPTH];
    expItem_t    expQ [$];
    expItem_t    monItem;
    int          checks = 0;
    int          passes = 0;
    int          cycleCount = 0;
    int          doneCount = 0;
    int          curLevel = 15;

    sprite_palette_bank #(
        .INDEX_W    (INDEX_W),
        .NUM_BANKS  (NUM_BANKS),
        .KEY_INDEX  (KEY_INDEX),
        .FADE_FRAMES(FADE_FRAMES)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_frame_tick  (frameTick),
        .i_wr_en       (wrEn),
        .i_wr_bank     (wrBank),
        .i_wr_index    (wrIndex),
        .i_wr_rgb      (wrRgb),
        .o_wr_ready    (wrReady),
        .i_pix_valid   (pixValid),
        .i_pix_bank    (pixBank),
        .i_pix_index   (pixIndex),
        .o_out_valid   (outValid),
        .o_red         (red),
        .o_green       (green),
        .o_blue        (blue),
        .o_transparent (transparent),
        .i_fade_out_req(fadeOutReq),
        .i_fade_in_req (fadeInReq),
        .o_fade_level  (fadeLevel),
        .o_fade_done   (fadeDone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Brightness model: each step below full knocks one unit off every channel, floored at zero.
    function automatic int fadeCh(input int ch, input int lvl);
        int d;
        d = 15 - lvl;
        return (ch > d) ? ch - d : 0;
    endfunction

    function automatic logic [11:0] fadeRgb(input logic [11:0] c, input int lvl);
        logic [3:0] r, g, b;
        r = 4'(fadeCh(int'(c[11:8]), lvl));
        g = 4'(fadeCh(int'(c[7:4]), lvl));
        b = 4'(fadeCh(int'(c[3:0]), lvl));
        return {r, g, b};
    endfunction

    always @(negedge clk) begin
        if (fadeDone === 1'b1) doneCount++;
        if (outValid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_out_valid", 1, 0);
            end else begin
                monItem = expQ.pop_front();
                checkOutput("pix_rgb", int'({red, green, blue}), int'(monItem.rgb));
                checkOutput("pix_transparent", int'(transparent), int'(monItem.trans));
                checkOutput("pix_latency", cycleCount - monItem.issueCycle, 2);
            end
        end
    end

    task automatic applyStimulus(input bit doWrite, input int wb, input int wi, input logic [11:0] wrgb,
                                 input bit doRead, input int rb, input int ri);
        expItem_t item;
        @(negedge clk);
        wrEn     = doWrite;
        wrBank   = 2'(wb);
        wrIndex  = 4'(wi);
        wrRgb    = wrgb;
        pixValid = doRead;
        pixBank  = 2'(rb);
        pixIndex = 4'(ri);
        if (doRead) begin
            item.rgb        = fadeRgb(modelMem[rb * ENTRIES + ri], curLevel);
            item.trans      = (ri == KEY_INDEX);
            item.issueCycle = cycleCount;
            expQ.push_back(item);
        end
        if (doWrite) modelMem[wb * ENTRIES + wi] = wrgb;
    endtask

    task automatic idle();
        @(negedge clk);
        wrEn     = 1'b0;
        pixValid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
    endtask

    task automatic pulseTick();
        @(negedge clk);
        frameTick = 1'b1;
        @(negedge clk);
        frameTick = 1'b0;
    endtask

    task automatic pulseReq(input bit o, input bit i);
        @(negedge clk);
        fadeOutReq = o;
        fadeInReq  = i;
        @(negedge clk);
        fadeOutReq = 1'b0;
        fadeInReq  = 1'b0;
    endtask

    task automatic readSome(input int n);
        for (int k = 0; k < n; k++)
            applyStimulus(0, 0, 0, 12'h0, 1, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
        idle();
        drain();
    endtask

    initial begin
        int cycles;
        for (int i = 0; i < DEPTH; i++) begin
            if (i % ENTRIES == KEY_INDEX) modelMem[i] = 12'hF0F;
            else modelMem[i] = {3{4'(i % ENTRIES)}};
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_wr_ready", int'(wrReady), 0);
        checkOutput("rst_out_valid", int'(outValid), 0);
        checkOutput("rst_rgb", int'({red, green, blue}), 0);
        checkOutput("rst_transparent", int'(transparent), 0);
        checkOutput("rst_fade_level", int'(fadeLevel), 15);
        checkOutput("rst_fade_done", int'(fadeDone), 0);

        // Writes and reads poked during init must be ignored.
        reset  = 1'b0;
        cycles = 0;
        while (wrReady !== 1'b1 && cycles < 200) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (cycles == 5) begin
                wrEn = 1'b1; wrBank = 2'd3; wrIndex = 4'd7; wrRgb = 12'hABC;
                pixValid = 1'b1; pixBank = 2'd1; pixIndex = 4'd2;
            end else if (cycles == 6) begin
                wrEn = 1'b0; pixValid = 1'b0;
            end
        end
        checkOutput("init_cycles", cycles, 64);

        applyStimulus(0, 0, 0, 12'h0, 1, 2, 5);
        for (int b = 0; b < NUM_BANKS; b++) applyStimulus(0, 0, 0, 12'h0, 1, b, KEY_INDEX);
        applyStimulus(0, 0, 0, 12'h0, 1, 3, 7);
        idle();
        drain();

        applyStimulus(1, 1, 3, 12'h7F3, 1, 1, 3);
        applyStimulus(0, 0, 0, 12'h0, 1, 1, 3);
        idle();
        drain();
        checkOutput("hold_out_valid", int'(outValid), 0);
        checkOutput("hold_rgb", int'({red, green, blue}), 12'h7F3);
        checkOutput("hold_transparent", int'(transparent), 0);

        pulseReq(1, 0);
        checkOutput("fade_out_start_level", int'(fadeLevel), 15);
        for (int t = 1; t <= 30; t++) begin
            pulseTick();
            checkOutput("fade_out_level", int'(fadeLevel), 15 - t / FADE_FRAMES);
            if (t == 14 || t == 30) begin
                curLevel = 15 - t / FADE_FRAMES;
                applyStimulus(0, 0, 0, 12'h0, 1, 1, 3);
                applyStimulus(0, 0, 0, 12'h0, 1, 2, 0);
                idle();
                drain();
            end
        end
        repeat (4) @(negedge clk);
        checkOutput("fade_out_done_count", doneCount, 1);

        pulseReq(0, 1);
        for (int t = 1; t <= 30; t++) begin
            pulseTick();
            checkOutput("fade_in_level", int'(fadeLevel), t / FADE_FRAMES);
        end
        repeat (4) @(negedge clk);
        checkOutput("fade_in_done_count", doneCount, 2);

        pulseReq(1, 0);
        for (int t = 1; t <= 12; t++) pulseTick();
        checkOutput("pre_reverse_level", int'(fadeLevel), 9);
        pulseReq(0, 1);
        for (int t = 1; t <= 12; t++) begin
            pulseTick();
            checkOutput("reverse_level", int'(fadeLevel), 9 + t / FADE_FRAMES);
        end
        repeat (4) @(negedge clk);
        checkOutput("reverse_done_count", doneCount, 3);

        pulseReq(1, 1);
        pulseTick();
        checkOutput("both_req_level_1", int'(fadeLevel), 15);
        pulseTick();
        checkOutput("both_req_level_2", int'(fadeLevel), 14);
        curLevel = 14;
        readSome(16);
        pulseReq(0, 1);
        pulseTick();
        pulseTick();
        curLevel = 15;
        checkOutput("recover_level", int'(fadeLevel), 15);

        for (int k = 0; k < 60; k++)
            applyStimulus(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                          12'($urandom), bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 15)));
        idle();
        readSome(20);

        cycles = 0;
        while (expQ.size() != 0 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("scoreboard_drained", expQ.size(), 0);
        checkOutput("final_done_count", doneCount, 4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sprite_palette_bank.md
Name: sprite_palette_bank

Overview:
Runtime-writable, multi-bank colour lookup for sprite pixel indices. It replaces fixed per-sprite palette ROMs and sits between the sprite address/ROM stage and the VGA colour mux. It adds three things: a bank-select input for per-sprite recolouring, a transparency flag for the key index, and a frame-stepped fade engine for screen transitions. After reset it self-initialises its storage with a default palette.

Parameters:
INDEX_W, 4, pixel index width; the bank depth is 2**INDEX_W.
NUM_BANKS, 4, number of palette banks; must be a power of two; BANK_W = clog2(NUM_BANKS).
COLOR_W, 4, width of each of the R, G and B channels.
KEY_INDEX, 0, index that reports transparent.
FADE_FRAMES, 2, number of frame_tick pulses per fade level step; legal values are 1 or more.

Ports:
Clk  in  1  system clock.
Reset  in  1  synchronous, active-high reset.
frame_tick  in  1  one-cycle pulse per video frame (vsync edge).
wr_en  in  1  palette write strobe.
wr_bank  in  BANK_W  bank to write.
wr_index  in  INDEX_W  entry to write.
wr_rgb  in  3*COLOR_W  colour to write, packed {R,G,B}.
wr_ready  out  1  high when writes are accepted.
pix_valid  in  1  pixel request valid.
pix_bank  in  BANK_W  bank selected for this pixel.
pix_index  in  INDEX_W  pixel colour index.
out_valid  out  1  colour output valid.
red, green, blue  out  COLOR_W each  faded colour channels.
transparent  out  1  pixel index equalled KEY_INDEX.
fade_out_req  in  1  pulse: start fading to black.
fade_in_req  in  1  pulse: start fading to full brightness.
fade_level  out  COLOR_W  current brightness, 0 = black, all-ones = full.
fade_done  out  1  one-cycle pulse when a fade reaches its endpoint.

Behaviour:
- Reset values: wr_ready=0, out_valid=0, red/green/blue=0, transparent=0, fade_level=all-ones, fade_done=0. The fade FSM resets to FULL and the init FSM resets to INIT.
- Init FSM has two states, INIT and RUN.
  - INIT walks every address, one write per cycle, bank-major, NUM_BANKS*2**INDEX_W cycles in total. It writes entry KEY_INDEX = {all-ones, 0, all-ones} (magenta key) and every other entry i = {i,i,i}, zero-extended or truncated to COLOR_W.
  - On the cycle after the last init write the FSM moves to RUN and wr_ready rises.
  - In INIT, wr_en is ignored and out_valid is forced to 0.
  - Reset asserted at any point restarts INIT from address 0.
- Writes are accepted only when wr_ready=1 and take one cycle.
- Read pipeline, 2 cycles:
  - Stage 1 is the synchronous RAM read at address {pix_bank, pix_index}; the transparency compare is registered alongside it.
  - Stage 2 applies the fade and registers the outputs.
  - out_valid equals pix_valid delayed by 2 cycles. When out_valid=0, red, green, blue and transparent hold their last values.
- Read/write collision on the same address in the same cycle gives read-before-write: the read returns the old data, and the new data is visible from the next cycle.
- Fade arithmetic, per channel: out = ch − (MAX − fade_level), saturating at 0, where MAX = 2**COLOR_W − 1. At fade_level=MAX the output equals the stored colour; at fade_level=0 the output is 0. Transparency is never affected by the fade.
- Fade FSM states are FULL, FADING_OUT, BLACK and FADING_IN. A tick counter counts frame_tick pulses modulo FADE_FRAMES.
  - FULL, on fade_out_req: go to FADING_OUT and clear the tick counter.
  - FADING_OUT: fade_level decrements by 1 every FADE_FRAMES ticks. When it reaches 0, go to BLACK and pulse fade_done.
  - BLACK, on fade_in_req: go to FADING_IN. The level increments by 1 every FADE_FRAMES ticks. When it reaches MAX, go to FULL and pulse fade_done.
  - A request for the opposite direction during a fade reverses immediately from the current level and clears the tick counter.
  - A request for the current direction, or one that matches the resting state, is ignored.
  - If fade_out_req and fade_in_req arrive together, fade_out_req wins.
  - A fade step applies to stage 2 from the cycle after the level register updates. There is no per-frame latching.

Decomposition:
- Package palette_pkg holds COLOR_W, the MAX constant, the packed rgb_t typedef, the fade_state_t enum (FULL/FADING_OUT/BLACK/FADING_IN) and the default-entry function.
- One sub-module, palette_fade_ctrl, contains the fade FSM, the tick counter, fade_level and fade_done.
- Storage is an inferred simple dual-port RAM inside the top module.

Test Plan:
- Reset, then count cycles to wr_ready: it rises after exactly 64 cycles (defaults). Reading bank 2 index 5 gives {5,5,5}, transparent=0, out_valid 2 cycles after pix_valid.
- Read index 0 of any bank: {F,0,F} with transparent=1.
- Write bank 1 index 3 = 12'h7F3, then read back: 7F3. A read of the same address in the same cycle as the write returns {3,3,3}; a read on the next cycle returns 7F3.
- wr_en during INIT: entry unchanged after init completes; it still holds its default value.
- fade_out_req with FADE_FRAMES=2 and 30 frame_ticks: fade_level reaches 0 after 30 ticks and fade_done pulses once. The entry 7F3 reads 000. At level 8 (7 steps down) the same entry reads 080.
- fade_in_req issued at level 9 during a fade-out: the fade reverses from level 9 upward. The level reaches F after 12 more ticks. fade_in_req and fade_out_req asserted together while in FULL start FADING_OUT.
